vdic_arith_stack_core: RTL and testbench

Responder-side core of the argument/command word protocol driven by the VDIC tester: accepts a stream of parity-protected data and command words, stacks up to MAX_ARGS arguments, executes NOP/AND/OR/XOR/ADD/SUB over the stacked arguments and returns one result word plus a status byte per command through a small output FIFO. It sits between the tester's input driver and the result monitor/scoreboard. The command and status encodings are those already used by the testbench package.

---
 rtl/vdic_arith_stack_core.sv | 202 ++++++++++++++++++++
 tb/tb_vdic_arith_stack_core.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vdic_arith_stack_core.sv
//------------------------------------------------------------------------------
// vdic_arith_stack_core
//
// Responder core for the VDIC argument/command word protocol. Parity-checked
// data words are stacked (up to MAX_ARGS). A command word folds the stacked
// arguments (AND/OR/XOR/ADD/SUB) one argument per cycle. Each command then
// emits one {result, status} record into a small first-word-fall-through
// output FIFO. NOP clears the stack and produces no record.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   din_valid/ready   : input word handshake (ready only while collecting)
//   din, din_cmd      : data word, or command code when din_cmd=1
//   din_parity        : even parity over {din_cmd, din, din_parity}
//   dout_valid/ready  : output record handshake (FWFT FIFO head)
//   dout, dout_status : result word and status byte of the head record
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module vdic_arith_stack_core #(
   parameter int DATA_W     = 8,
   parameter int MAX_ARGS   = 9,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              din_valid,
   output logic              din_ready,
   input  logic [DATA_W-1:0] din,
   input  logic              din_cmd,
   input  logic              din_parity,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic [DATA_W-1:0] dout,
   output logic [7:0]        dout_status
);

   localparam int CNT_W = $clog2(MAX_ARGS + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int REC_W = DATA_W + 8;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ARGS);
   localparam logic [PTR_W:0]   PTR_ONE = (PTR_W + 1)'(1);

   localparam logic [7:0] ST_MISSING  = 8'h01;
   localparam logic [7:0] ST_STK_OVF  = 8'h02;
   localparam logic [7:0] ST_FIFO_OVF = 8'h04;
   localparam logic [7:0] ST_DPAR     = 8'h20;
   localparam logic [7:0] ST_CPAR     = 8'h40;
   localparam logic [7:0] ST_INVALID  = 8'h80;

   localparam logic [DATA_W-1:0] CMD_NOP = DATA_W'(8'h00);
   localparam logic [DATA_W-1:0] CMD_AND = DATA_W'(8'h01);
   localparam logic [DATA_W-1:0] CMD_OR  = DATA_W'(8'h02);
   localparam logic [DATA_W-1:0] CMD_XOR = DATA_W'(8'h03);
   localparam logic [DATA_W-1:0] CMD_ADD = DATA_W'(8'h10);
   localparam logic [DATA_W-1:0] CMD_SUB = DATA_W'(8'h20);

   typedef enum logic [1:0] {COLLECT, EXEC, EMIT} state_t;

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    count_reg, count_next;
   logic [CNT_W-1:0]    idx_reg, idx_next;
   logic [7:0]          sticky_reg, sticky_next;   // holds only 0x02 / 0x20
   logic [7:0]          status_reg, status_next;
   logic [DATA_W-1:0]   acc_reg, acc_next;
   logic [DATA_W-1:0]   op_reg, op_next;
   logic                pending_reg;               // dropped-record flag (0x04)

   logic [DATA_W-1:0]   arg_mem [MAX_ARGS];
   logic [REC_W-1:0]    fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]      wr_ptr_reg, rd_ptr_reg;

   logic parity_ok, valid_op, push, fifo_wr, fifo_push, fifo_pop, fifo_full;

   assign parity_ok = ~(^{din_cmd, din, din_parity});
   assign valid_op  = (din == CMD_AND) || (din == CMD_OR) || (din == CMD_XOR) ||
                      (din == CMD_ADD) || (din == CMD_SUB);

   // FIFO bookkeeping: pointers carry one extra wrap bit
   assign dout_valid = (wr_ptr_reg != rd_ptr_reg);
   assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                       (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
   assign fifo_pop   = dout_valid && dout_ready;
   // a same-cycle read frees a slot, so a write into a full FIFO still lands
   assign fifo_push  = fifo_wr && (!fifo_full || fifo_pop);
   assign {dout_status, dout} = dout_valid ? fifo_mem[rd_ptr_reg[PTR_W-1:0]] : '0;

   always_comb begin
      state_next  = state_reg;
      count_next  = count_reg;
      idx_next    = idx_reg;
      sticky_next = sticky_reg;
      status_next = status_reg;
      acc_next    = acc_reg;
      op_next     = op_reg;
      push        = 1'b0;
      fifo_wr     = 1'b0;
      din_ready   = 1'b0;
      case (state_reg)
         COLLECT: begin
            din_ready = 1'b1;
            if (din_valid) begin
               if (!din_cmd) begin
                  if (!parity_ok)
                     sticky_next = sticky_reg | ST_DPAR;
                  else if (count_reg == CNT_MAX)
                     sticky_next = sticky_reg | ST_STK_OVF;
                  else begin
                     push       = 1'b1;
                     count_next = count_reg + CNT_ONE;
                  end
               end else if (!parity_ok) begin
                  acc_next    = '0;
                  status_next = ST_CPAR | sticky_reg;
                  state_next  = EMIT;
               end else if (din == CMD_NOP) begin
                  count_next  = '0;
                  sticky_next = '0;
               end else if (!valid_op) begin
                  acc_next    = '0;
                  status_next = ST_INVALID | sticky_reg;
                  state_next  = EMIT;
               end else if (count_reg < CNT_TWO) begin
                  acc_next    = '0;
                  status_next = ST_MISSING | sticky_reg;
                  state_next  = EMIT;
               end else if (sticky_reg != 8'h00) begin
                  acc_next    = '0;
                  status_next = sticky_reg;
                  state_next  = EMIT;
               end else begin
                  acc_next    = arg_mem[0];
                  op_next     = din;
                  idx_next    = CNT_ONE;
                  status_next = 8'h00;
                  state_next  = EXEC;
               end
            end
         end
         EXEC: begin
            case (op_reg)
               CMD_AND: acc_next = acc_reg & arg_mem[idx_reg];
               CMD_OR:  acc_next = acc_reg | arg_mem[idx_reg];
               CMD_XOR: acc_next = acc_reg ^ arg_mem[idx_reg];
               CMD_SUB: acc_next = acc_reg - arg_mem[idx_reg];
               default: acc_next = acc_reg + arg_mem[idx_reg];
            endcase
            idx_next = idx_reg + CNT_ONE;
            if (idx_reg == count_reg - CNT_ONE)
               state_next = EMIT;
         end
         EMIT: begin
            fifo_wr     = 1'b1;
            count_next  = '0;
            sticky_next = '0;
            state_next  = COLLECT;
         end
         default: state_next = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= COLLECT;
         count_reg   <= '0;
         idx_reg     <= '0;
         sticky_reg  <= '0;
         status_reg  <= '0;
         acc_reg     <= '0;
         op_reg      <= '0;
         pending_reg <= 1'b0;
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         count_reg  <= count_next;
         idx_reg    <= idx_next;
         sticky_reg <= sticky_next;
         status_reg <= status_next;
         acc_reg    <= acc_next;
         op_reg     <= op_next;
         if (fifo_wr)
            pending_reg <= !fifo_push;
         if (fifo_push)
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (fifo_pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
   end

   // storage arrays carry no reset; pointers/count gate visibility
   always_ff @(posedge clk) begin
      if (push)
         arg_mem[count_reg] <= din;
      if (fifo_push)
         fifo_mem[wr_ptr_reg[PTR_W-1:0]] <=
            {status_reg | (pending_reg ? ST_FIFO_OVF : 8'h00), acc_reg};
   end

endmodule

// File: tb/tb_vdic_arith_stack_core.sv
`timescale 1ns/1ps
module tb_vdic_arith_stack_core;

   logic       clk = 1'b0;
   logic       rst;
   logic       din_valid;
   logic       din_ready;
   logic [7:0] din;
   logic       din_cmd;
   logic       din_parity;
   logic       dout_valid;
   logic       dout_ready;
   logic [7:0] dout;
   logic [7:0] dout_status;

   vdic_arith_stack_core #(.DATA_W(8), .MAX_ARGS(9), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .din_valid(din_valid), .din_ready(din_ready), .din(din),
      .din_cmd(din_cmd), .din_parity(din_parity),
      .dout_valid(dout_valid), .dout_ready(dout_ready),
      .dout(dout), .dout_status(dout_status)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   int         m_args[$];
   logic [7:0] m_sticky;
   bit         m_pend;
   logic [7:0] exp_val[$];
   logic [7:0] exp_st[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // starts and ends at a negedge; returns in the cycle after the transfer
   task automatic send_word(input bit cmd, input logic [7:0] d, input bit bad);
      int guard = 0;
      din_valid  = 1'b1;
      din_cmd    = cmd;
      din        = d;
      din_parity = bad ? ~(^{cmd, d}) : (^{cmd, d});
      while (!din_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) check_eq("din_ready_timeout", din_ready, 1);
      @(posedge clk);
      @(negedge clk);
      din_valid = 1'b0;
   endtask

   task automatic send_data(input logic [7:0] d, input bit bad);
      if (bad) m_sticky |= 8'h20;
      else if (m_args.size() == 9) m_sticky |= 8'h02;
      else m_args.push_back(int'(d));
      send_word(1'b0, d, bad);
   endtask

   task automatic do_cmd(input logic [7:0] code, input bit bad);
      bit         rec = 1'b1;
      logic [7:0] val = 8'h00;
      logic [7:0] st  = 8'h00;
      int         lat = 2;
      int         acc;
      int         k, first_dv;
      bit         start_empty;
      if (bad) st = 8'h40 | m_sticky;
      else if (code == 8'h00) begin rec = 1'b0; lat = 1; end
      else if (!(code inside {8'h01, 8'h02, 8'h03, 8'h10, 8'h20})) st = 8'h80 | m_sticky;
      else if (m_args.size() < 2) st = 8'h01 | m_sticky;
      else if (m_sticky != 8'h00) st = m_sticky;
      else begin
         acc = m_args[0];
         for (int i = 1; i < m_args.size(); i++) begin
            case (code)
               8'h01: acc = acc & m_args[i];
               8'h02: acc = acc | m_args[i];
               8'h03: acc = acc ^ m_args[i];
               8'h10: acc = acc + m_args[i];
               default: acc = acc - m_args[i];
            endcase
         end
         val = acc[7:0];
         lat = m_args.size() + 1;
      end
      start_empty = (exp_val.size() == 0);
      send_word(1'b1, code, bad);
      k = 1;
      first_dv = 0;
      forever begin
         if (dout_valid && first_dv == 0) first_dv = k;
         if (din_ready || k >= 40) break;
         @(negedge clk);
         k++;
      end
      check_eq($sformatf("ready_latency_cmd%02h", code), k, lat);
      if (start_empty) check_eq($sformatf("record_latency_cmd%02h", code), first_dv, rec ? lat : 0);
      if (rec) begin
         if (exp_val.size() < 4) begin
            exp_val.push_back(val);
            exp_st.push_back(st | (m_pend ? 8'h04 : 8'h00));
            m_pend = 1'b0;
         end else begin
            m_pend = 1'b1;
         end
      end
      $display("cmd %02h bad=%0d args=%0d rec=%0d val=%02h st=%02h", code, bad, m_args.size(), rec, val, st);
      m_args.delete();
      m_sticky = 8'h00;
   endtask

   task automatic drain();
      while (exp_val.size() > 0) begin
         check_eq("dout_valid", dout_valid, 1);
         check_eq("dout", dout, exp_val[0]);
         check_eq("dout_status", dout_status, exp_st[0]);
         $display("record dout=%02h status=%02h", dout, dout_status);
         dout_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         dout_ready = 1'b0;
         void'(exp_val.pop_front());
         void'(exp_st.pop_front());
      end
      check_eq("fifo_empty", dout_valid, 0);
   endtask

   task automatic two_arg_add();
      send_data(8'($urandom_range(0, 255)), 1'b0);
      send_data(8'($urandom_range(0, 255)), 1'b0);
      do_cmd(8'h10, 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ops[5];
      int n;
      logic [7:0] code;
      ops = '{8'h01, 8'h02, 8'h03, 8'h10, 8'h20};
      rst = 1'b1; din_valid = 1'b0; din = 8'h00; din_cmd = 1'b0; din_parity = 1'b0;
      dout_ready = 1'b0;
      m_sticky = 8'h00; m_pend = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("reset_din_ready", din_ready, 1);
      check_eq("reset_dout_valid", dout_valid, 0);
      check_eq("reset_dout", dout, 0);
      check_eq("reset_dout_status", dout_status, 0);

      // directed cases
      send_data(8'h0F, 0); send_data(8'h3C, 0); do_cmd(8'h10, 0); drain();
      send_data(8'h10, 0); send_data(8'h03, 0); send_data(8'h01, 0); do_cmd(8'h20, 0); drain();
      send_data(8'hFF, 0); send_data(8'h02, 0); do_cmd(8'h10, 0); drain();
      for (int i = 0; i < 10; i++) send_data(8'($urandom_range(0, 255)), 0);
      do_cmd(8'h03, 0); drain();
      send_data(8'h5A, 0); do_cmd(8'h01, 0); drain();
      do_cmd(8'h55, 0); drain();
      send_data(8'h11, 1); send_data(8'h22, 0); send_data(8'h33, 0); do_cmd(8'h02, 0); drain();
      send_data(8'h44, 0); send_data(8'h55, 0); do_cmd(8'h10, 1); drain();
      send_data(8'h01, 0); send_data(8'h02, 0); do_cmd(8'h00, 0);
      send_data(8'h07, 0); send_data(8'h70, 0); do_cmd(8'h02, 0); drain();
      for (int i = 0; i < 9; i++) send_data(8'(i * 29 + 3), 0);
      do_cmd(8'h10, 0); drain();

      // output FIFO overflow with consumer stalled
      for (int i = 0; i < 5; i++) two_arg_add();
      check_eq("ovf_head_valid", dout_valid, 1);
      drain();
      two_arg_add(); drain();

      // reset during EXEC of an 8-argument ADD
      for (int i = 0; i < 8; i++) send_data(8'($urandom_range(0, 255)), 0);
      send_word(1'b1, 8'h10, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst_dout_valid", dout_valid, 0);
      check_eq("post_rst_din_ready", din_ready, 1);
      m_args.delete(); m_sticky = 8'h00; m_pend = 1'b0;
      repeat (12) @(negedge clk);
      check_eq("post_rst_no_record", dout_valid, 0);
      two_arg_add(); drain();

      // randomized transactions
      for (int t = 0; t < 60; t++) begin
         n = $urandom_range(0, 11);
         for (int i = 0; i < n; i++)
            send_data(8'($urandom_range(0, 255)),
                      (m_args.size() < 9) && ($urandom_range(0, 11) == 0));
         case ($urandom_range(0, 19))
            0: do_cmd(8'h00, 0);
            1: do_cmd(8'($urandom_range(0, 255)), 0);
            2: do_cmd(ops[$urandom_range(0, 4)], 1);
            default: begin
               code = ops[$urandom_range(0, 4)];
               do_cmd(code, 0);
            end
         endcase
         drain();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
